// File: rtl/branch_resolve_queue.sv
// ============================================================================
// Module   : branch_resolve_queue
// Purpose  : In-order branch queue between gshare prediction and execute
//            resolution; emits predictor updates and mispredict redirects.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_queue #(
  parameter int DEPTH      = 4,
  parameter int PC_WIDTH   = 9,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                     in_Clk,
  input  logic                     in_Rst_N,
  input  logic                     in_push,
  input  logic [PC_WIDTH-1:0]      in_push_PC,
  input  logic                     in_push_pred,
  input  logic [ADDR_WIDTH-1:0]    in_push_next_PC,
  input  logic                     in_resolve,
  input  logic                     in_resolve_taken,
  input  logic [ADDR_WIDTH-1:0]    in_resolve_target,
  input  logic                     in_flush,
  output logic                     out_full,
  output logic                     out_empty,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic                     out_update_valid,
  output logic [PC_WIDTH-1:0]      out_update_PC,
  output logic                     out_update_taken,
  output logic                     out_mispredict,
  output logic [ADDR_WIDTH-1:0]    out_redirect_PC
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DROP = 1'b1
  } state_t;

  logic [PC_WIDTH-1:0]   pc_mem_q   [DEPTH];
  logic                  pred_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] next_mem_q [DEPTH];

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  upd_valid_q, upd_valid_d;
  logic [PC_WIDTH-1:0]   upd_pc_q, upd_pc_d;
  logic                  upd_taken_q, upd_taken_d;
  logic                  mispred_q, mispred_d;
  logic [ADDR_WIDTH-1:0] redirect_q, redirect_d;

  logic w_full, w_empty, w_resolve_ok, w_mispredict, w_push_ok;

  assign w_full       = (count_q == CNT_W'(DEPTH));
  assign w_empty      = (count_q == '0);
  assign w_resolve_ok = in_resolve && !w_empty && !in_flush;
  assign w_mispredict = w_resolve_ok && (pred_mem_q[rd_q] != in_resolve_taken);
  // A full queue still takes a push when the same edge pops the oldest entry.
  assign w_push_ok    = in_push && !in_flush && (state_q == ST_RUN) &&
                        (!w_full || w_resolve_ok) && !w_mispredict;

  always_comb begin
    state_d     = ST_RUN;
    rd_d        = rd_q;
    wr_d        = wr_q;
    count_d     = count_q;
    upd_valid_d = 1'b0;
    upd_pc_d    = upd_pc_q;
    upd_taken_d = upd_taken_q;
    mispred_d   = 1'b0;
    redirect_d  = redirect_q;

    if (in_flush) begin
      rd_d    = wr_q;
      count_d = '0;
    end else begin
      if (w_resolve_ok) begin
        upd_valid_d = 1'b1;
        upd_pc_d    = pc_mem_q[rd_q];
        upd_taken_d = in_resolve_taken;
        mispred_d   = w_mispredict;
        redirect_d  = in_resolve_taken ? in_resolve_target : next_mem_q[rd_q];
      end
      if (w_mispredict) begin
        // Everything younger than the mispredicted branch is wrong-path.
        rd_d    = wr_q;
        count_d = '0;
        state_d = ST_DROP;
      end else begin
        if (w_push_ok)    wr_d = wr_q + PTR_W'(1);
        if (w_resolve_ok) rd_d = rd_q + PTR_W'(1);
        count_d = count_q + CNT_W'(w_push_ok) - CNT_W'(w_resolve_ok);
      end
    end
  end

  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      state_q     <= ST_RUN;
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
      mispred_q   <= 1'b0;
      redirect_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      count_q     <= count_d;
      upd_valid_q <= upd_valid_d;
      upd_pc_q    <= upd_pc_d;
      upd_taken_q <= upd_taken_d;
      mispred_q   <= mispred_d;
      redirect_q  <= redirect_d;
    end
  end

  always_ff @(posedge in_Clk) begin
    if (w_push_ok) begin
      pc_mem_q[wr_q]   <= in_push_PC;
      pred_mem_q[wr_q] <= in_push_pred;
      next_mem_q[wr_q] <= in_push_next_PC;
    end
  end

  assign out_full         = w_full;
  assign out_empty        = w_empty;
  assign out_count        = count_q;
  assign out_update_valid = upd_valid_q;
  assign out_update_PC    = upd_pc_q;
  assign out_update_taken = upd_taken_q;
  assign out_mispredict   = mispred_q;
  assign out_redirect_PC  = redirect_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
// ============================================================================
// Module   : tb_branch_resolve_queue
// Purpose  : Directed vector bench for branch_resolve_queue (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_queue;

  logic        clk;
  logic        rst_n;
  logic        push;
  logic [8:0]  push_pc;
  logic        push_pred;
  logic [63:0] push_next;
  logic        resolve;
  logic        res_taken;
  logic [63:0] res_target;
  logic        flush;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        upd_valid;
  logic [8:0]  upd_pc;
  logic        upd_taken;
  logic        mispred;
  logic [63:0] redirect;

  int checks = 0;
  int errors = 0;

  branch_resolve_queue #(
    .DEPTH(4),
    .PC_WIDTH(9),
    .ADDR_WIDTH(64)
  ) dut (
    .in_Clk            (clk),
    .in_Rst_N          (rst_n),
    .in_push           (push),
    .in_push_PC        (push_pc),
    .in_push_pred      (push_pred),
    .in_push_next_PC   (push_next),
    .in_resolve        (resolve),
    .in_resolve_taken  (res_taken),
    .in_resolve_target (res_target),
    .in_flush          (flush),
    .out_full          (full),
    .out_empty         (empty),
    .out_count         (count),
    .out_update_valid  (upd_valid),
    .out_update_PC     (upd_pc),
    .out_update_taken  (upd_taken),
    .out_mispredict    (mispred),
    .out_redirect_PC   (redirect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        p;
    logic [8:0]  pc;
    logic        pr;
    logic [63:0] nx;
    logic        r;
    logic        tk;
    logic [63:0] tg;
    logic        fl;
    logic [2:0]  e_cnt;
    logic        e_uv;
    logic [8:0]  e_upc;
    logic        e_ut;
    logic        e_mis;
    logic [63:0] e_rpc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic p, input logic [8:0] pc, input logic pr,
                              input logic [63:0] nx, input logic r, input logic tk,
                              input logic [63:0] tg, input logic fl, input logic [2:0] c,
                              input logic uv, input logic [8:0] upc, input logic ut,
                              input logic mis, input logic [63:0] rpc);
    vec_t v;
    v.p = p; v.pc = pc; v.pr = pr; v.nx = nx; v.r = r; v.tk = tk; v.tg = tg; v.fl = fl;
    v.e_cnt = c; v.e_uv = uv; v.e_upc = upc; v.e_ut = ut; v.e_mis = mis; v.e_rpc = rpc;
    return v;
  endfunction

  task automatic drive(input logic p, input logic [8:0] pc, input logic pr,
                       input logic [63:0] nx, input logic r, input logic tk,
                       input logic [63:0] tg, input logic fl);
    push = p; push_pc = pc; push_pred = pr; push_next = nx;
    resolve = r; res_taken = tk; res_target = tg; flush = fl;
  endtask

  task automatic expect_out(input string nm, input logic [2:0] c, input logic uv,
                            input logic [8:0] upc, input logic ut, input logic mis,
                            input logic [63:0] rpc);
    logic [80:0] act, req;
    act = {count, full, empty, upd_valid, upd_pc, upd_taken, mispred, redirect};
    req = {c, (c == 3'd4), (c == 3'd0), uv, upc, ut, mis, rpc};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual cnt=%0d full=%b empty=%b uv=%b pc=%h tk=%b mis=%b rpc=%h required cnt=%0d full=%b empty=%b uv=%b pc=%h tk=%b mis=%b rpc=%h",
               nm, count, full, empty, upd_valid, upd_pc, upd_taken, mispred, redirect,
               c, (c == 3'd4), (c == 3'd0), uv, upc, ut, mis, rpc);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input vec_t v, input string nm);
    @(negedge clk);
    drive(v.p, v.pc, v.pr, v.nx, v.r, v.tk, v.tg, v.fl);
    @(posedge clk);
    #1;
    expect_out(nm, v.e_cnt, v.e_uv, v.e_upc, v.e_ut, v.e_mis, v.e_rpc);
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) step(tbl[i], $sformatf("vec%0d", i));
  endtask

  initial begin
    // Part A: single round trip, fill to full, overflow drop, push+pop at full.
    tbl.push_back(mk(1, 9'h011, 1, 64'h1004, 0, 0, 64'h0,   0, 3'd1, 0, 9'h000, 0, 0, 64'h0));
    tbl.push_back(mk(0, 9'h000, 0, 64'h0,    1, 1, 64'h2000,0, 3'd0, 1, 9'h011, 1, 0, 64'h2000));
    tbl.push_back(mk(0, 9'h000, 0, 64'h0,    0, 0, 64'h0,   0, 3'd0, 0, 9'h011, 1, 0, 64'h2000));
    tbl.push_back(mk(1, 9'h020, 1, 64'h100,  0, 0, 64'h0,   0, 3'd1, 0, 9'h011, 1, 0, 64'h2000));
    tbl.push_back(mk(1, 9'h021, 1, 64'h104,  0, 0, 64'h0,   0, 3'd2, 0, 9'h011, 1, 0, 64'h2000));
    tbl.push_back(mk(1, 9'h022, 1, 64'h108,  0, 0, 64'h0,   0, 3'd3, 0, 9'h011, 1, 0, 64'h2000));
    tbl.push_back(mk(1, 9'h023, 1, 64'h10C,  0, 0, 64'h0,   0, 3'd4, 0, 9'h011, 1, 0, 64'h2000));
    tbl.push_back(mk(1, 9'h024, 1, 64'h110,  0, 0, 64'h0,   0, 3'd4, 0, 9'h011, 1, 0, 64'h2000));
    tbl.push_back(mk(1, 9'h025, 1, 64'h114,  1, 1, 64'h500, 0, 3'd4, 1, 9'h020, 1, 0, 64'h500));
    // Part B: mispredict, DROP cycle, taken-target redirect, empty resolves.
    tbl.push_back(mk(1, 9'h030, 1, 64'h1004, 0, 0, 64'h0,   0, 3'd1, 0, 9'h029, 1, 0, 64'h607));
    tbl.push_back(mk(1, 9'h031, 0, 64'h2004, 0, 0, 64'h0,   0, 3'd2, 0, 9'h029, 1, 0, 64'h607));
    tbl.push_back(mk(1, 9'h032, 1, 64'h3004, 0, 0, 64'h0,   0, 3'd3, 0, 9'h029, 1, 0, 64'h607));
    tbl.push_back(mk(1, 9'h033, 1, 64'h0,    1, 0, 64'h9999,0, 3'd0, 1, 9'h030, 0, 1, 64'h1004));
    tbl.push_back(mk(1, 9'h034, 1, 64'h0,    0, 0, 64'h0,   0, 3'd0, 0, 9'h030, 0, 0, 64'h1004));
    tbl.push_back(mk(1, 9'h035, 0, 64'h4004, 0, 0, 64'h0,   0, 3'd1, 0, 9'h030, 0, 0, 64'h1004));
    tbl.push_back(mk(0, 9'h000, 0, 64'h0,    1, 1, 64'hABC0,0, 3'd0, 1, 9'h035, 1, 1, 64'hABC0));
    tbl.push_back(mk(0, 9'h000, 0, 64'h0,    1, 1, 64'hFFFF,0, 3'd0, 0, 9'h035, 1, 0, 64'hABC0));
    tbl.push_back(mk(0, 9'h000, 0, 64'h0,    1, 0, 64'hEEEE,0, 3'd0, 0, 9'h035, 1, 0, 64'hABC0));
    tbl.push_back(mk(1, 9'h036, 1, 64'h5004, 1, 1, 64'h6000,0, 3'd1, 0, 9'h035, 1, 0, 64'hABC0));
    tbl.push_back(mk(0, 9'h000, 0, 64'h0,    1, 1, 64'h7000,0, 3'd0, 1, 9'h036, 1, 0, 64'h7000));

    drive(0, 9'h0, 0, 64'h0, 0, 0, 64'h0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 3'd0, 0, 9'h000, 0, 0, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_range(0, 8);

    // Queue holds 21,22,23,25; push+pop at full walks the pointers round twice.
    for (int i = 0; i < 8; i++) begin
      logic [8:0] exp_pc;
      exp_pc = (i < 3) ? 9'(9'h021 + i) : 9'(9'h022 + i);
      @(negedge clk);
      drive(1, 9'(9'h026 + i), 1, 64'(64'h200 + i), 1, 1, 64'(64'h600 + i), 0);
      @(posedge clk);
      #1;
      expect_out($sformatf("wrap%0d", i), 3'd4, 1, exp_pc, 1, 0, 64'(64'h600 + i));
    end

    // Flush beats a would-be mispredicting resolve and a push.
    @(negedge clk);
    drive(1, 9'h0FF, 1, 64'h0, 1, 0, 64'h1234, 1);
    @(posedge clk);
    #1;
    expect_out("flush", 3'd0, 0, 9'h029, 1, 0, 64'h607);

    run_range(9, 19);

    // Asynchronous reset with entries queued and a strobe visible.
    step(mk(1, 9'h040, 1, 64'h0, 0, 0, 64'h0, 0, 3'd1, 0, 9'h036, 1, 0, 64'h7000), "rq0");
    step(mk(1, 9'h041, 1, 64'h0, 0, 0, 64'h0, 0, 3'd2, 0, 9'h036, 1, 0, 64'h7000), "rq1");
    step(mk(1, 9'h042, 1, 64'h0, 0, 0, 64'h0, 0, 3'd3, 0, 9'h036, 1, 0, 64'h7000), "rq2");
    step(mk(0, 9'h000, 0, 64'h0, 1, 1, 64'h8000, 0, 3'd2, 1, 9'h040, 1, 0, 64'h8000), "rq3");
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 3'd0, 0, 9'h000, 0, 0, 64'h0);
    @(negedge clk);
    drive(0, 9'h0, 0, 64'h0, 0, 0, 64'h0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_out("post_rst", 3'd0, 0, 9'h000, 0, 0, 64'h0);
    step(mk(1, 9'h050, 0, 64'h9004, 0, 0, 64'h0, 0, 3'd1, 0, 9'h000, 0, 0, 64'h0), "after_rst_push");
    step(mk(0, 9'h000, 0, 64'h0, 1, 0, 64'h0, 0, 3'd0, 1, 9'h050, 0, 0, 64'h9004), "after_rst_pop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order queue between fetch-stage branch prediction and execute-stage branch resolution. Each fetched conditional branch pushes its predictor index PC, the gshare prediction and its fall-through address. When execute resolves the oldest branch, the block does three things: it pops the entry, emits a one-cycle predictor update (PC plus actual outcome, which drives the gshare `in_PC`/`in_hit` path), and on a wrong prediction raises a mispredict with the redirect address and flushes all younger entries.

## Interface
- `DEPTH`, 4, queue entries; power of two, 2..16
- `PC_WIDTH`, 9, predictor index width
- `ADDR_WIDTH`, 64, full address width
- `in_Clk` input 1 — clock, rising edge
- `in_Rst_N` input 1 — reset; one clock; reset is asynchronous and active-low
- `in_push` input 1 — fetch enqueues a branch
- `in_push_PC` input PC_WIDTH — predictor index of the branch
- `in_push_pred` input 1 — gshare prediction (1 = taken)
- `in_push_next_PC` input ADDR_WIDTH — fall-through address
- `in_resolve` input 1 — execute resolves the oldest branch
- `in_resolve_taken` input 1 — actual outcome
- `in_resolve_target` input ADDR_WIDTH — actual taken target
- `in_flush` input 1 — pipeline flush (trap); empties the queue
- `out_full` output 1 — count == DEPTH
- `out_empty` output 1 — count == 0
- `out_count` output $clog2(DEPTH)+1 — occupancy
- `out_update_valid` output 1 — predictor update strobe
- `out_update_PC` output PC_WIDTH — PC to update
- `out_update_taken` output 1 — outcome to shift and train
- `out_mispredict` output 1 — redirect strobe
- `out_redirect_PC` output ADDR_WIDTH — correct next fetch address

## Operation
- Storage: circular buffer. Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. A separate occupancy counter tracks fill level.
- Push is accepted when `in_push` is high, the queue is not full and the queue is not in DROP state. Otherwise the push is silently discarded; fetch must honour `out_full`.
- Resolve is accepted when `in_resolve` is high and the queue is not empty. A resolve on an empty queue is ignored and raises no strobe.
- On an accepted resolve, the oldest entry is popped. Its registered outputs, valid next cycle, are:
  - `out_update_valid` = 1
  - `out_update_PC` = the entry's PC
  - `out_update_taken` = `in_resolve_taken`
  - `out_mispredict` = (entry pred != `in_resolve_taken`)
  - `out_redirect_PC` = `in_resolve_taken` ? `in_resolve_target` : entry next_PC
- Mispredict: at the same edge, all remaining entries are discarded (pointers equal, count 0) and any push in that cycle is dropped.
- State machine:
  - RUN → DROP on an accepted mispredicting resolve.
  - DROP lasts exactly one cycle (the cycle `out_mispredict` is high) and rejects all pushes, because those are wrong-path fetches.
  - DROP → RUN unconditionally.
- `in_flush` has priority over everything. It empties the queue, ignores any push or resolve in that cycle, emits no update or mispredict strobe, and forces RUN.
- Push and resolve in the same cycle with no mispredict: count unchanged. This is legal even when the queue is full, because the pop frees a slot in the same edge.
- Push and resolve in the same cycle on an empty queue: the push is accepted, the resolve is ignored, and count becomes 1.

## Timing
- Reset (asynchronous assert, synchronous release):
  - pointers and count = 0, state = RUN, `out_empty` = 1
  - `out_full`, `out_update_valid`, `out_mispredict` = 0
  - `out_update_PC`, `out_update_taken`, `out_redirect_PC` = 0
- Reset mid-operation discards all entries and any pending strobe.
- `out_full`, `out_empty` and `out_count` reflect state after the last edge; no combinational path from inputs.
- Push-to-resolvable latency is 1 cycle: an entry pushed at edge N can be resolved in the cycle after edge N.
- Resolve-to-strobe latency is 1 cycle. `out_update_valid` and `out_mispredict` are single-cycle pulses; back-to-back resolves give back-to-back pulses.
- Data outputs hold their last value when the strobes are low.

## Test plan
- Reset, then push PC=0x011 pred=1 next=0x1004, then resolve taken=1 target=0x2000 → next cycle `out_update_valid`=1, PC=0x011, taken=1, `out_mispredict`=0, count=0.
- Push 4 entries (DEPTH=4) → `out_full`=1; a 5th push is dropped. Then push+resolve in the same cycle → count stays 4 and FIFO order is preserved over 8 further pops across pointer wrap.
- 3 entries, oldest pred=1 next=0x1004, resolve taken=0 with a push in the same cycle → `out_mispredict`=1, `out_redirect_PC`=0x1004, count=0; a push in the following (DROP) cycle is dropped; a push one cycle later is accepted, count=1.
- Oldest pred=0, resolve taken=1 target=0xABC0 → `out_redirect_PC`=0xABC0, `out_update_taken`=1.
- Resolve on an empty queue → no strobe, count 0. `in_flush` concurrent with a mispredicting resolve → count=0 and no strobe.
- Assert `in_Rst_N`=0 asynchronously with 2 entries queued and a strobe pending → all outputs immediately take their reset values.
